// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The decoder imports op_t from here to encode the unit's operation field.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_UDIV = 2'd1,
    OP_SDIV = 2'd2
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The reserved encoding 2'b11 executes as a multiply.
  function automatic op_t decode_op(input logic [1:0] raw);
    case (raw)
      2'b01:   return OP_UDIV;
      2'b10:   return OP_SDIV;
      default: return OP_MUL;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue and register-file writeback bundle between the decode stage and muldiv_unit.
// The decode stage uses the master modport; the execution unit uses the slave modport.
interface muldiv_if #(
  parameter int XLEN = muldiv_pkg::XLEN
);

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic [3:0]      dest;
  logic            flush;
  logic            busy;
  logic            wb_en;
  logic [3:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  modport master (
    output start, op, opA, opB, dest, flush,
    input  busy, wb_en, wb_addr, wb_data
  );

  modport slave (
    input  start, op, opA, opB, dest, flush,
    output busy, wb_en, wb_addr, wb_data
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: a shift-add multiply step or a restoring divide step.
// Multiply: acc=product, a=multiplicand, b=multiplier. Divide: acc=remainder, a=dividend/quotient, b=divisor.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {acc_i, a_i[XLEN-1]};
    diff    = shifted - {1'b0, b_i};
    acc_o   = acc_i;
    a_o     = a_i;
    b_o     = b_i;
    if (is_div) begin
      // A clear borrow bit means the divisor fits, so this quotient bit is 1.
      if (!diff[XLEN]) begin
        acc_o = diff[XLEN-1:0];
        a_o   = {a_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = shifted[XLEN-1:0];
        a_o   = {a_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = acc_i + (b_i[0] ? a_i : '0);
      a_o   = a_i << 1;
      b_o   = b_i >> 1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one iteration per cycle, result returned as a
// one-cycle register-file writeback pulse. The decoder stalls issue while busy is high.
module muldiv_unit #(
  parameter int XLEN  = muldiv_pkg::XLEN,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  import muldiv_pkg::*;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t             op_q, op_d;
  logic [3:0]      dest_q, dest_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [3:0]      wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic [XLEN-1:0] acc_step, a_step, b_step;
  logic [XLEN-1:0] quot, result;
  logic [XLEN-1:0] abs_a, abs_b;
  op_t             op_in;
  logic            div_zero;
  logic            is_div;

  assign is_div = (op_q != OP_MUL);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (is_div),
    .acc_i  (acc_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .acc_o  (acc_step),
    .a_o    (a_step),
    .b_o    (b_step)
  );

  always_comb begin
    op_in    = decode_op(bus.op);
    div_zero = (op_in != OP_MUL) && (bus.opB == '0);
    abs_a    = bus.opA[XLEN-1] ? -bus.opA : bus.opA;
    abs_b    = bus.opB[XLEN-1] ? -bus.opB : bus.opB;
    quot     = neg_q ? -a_step : a_step;
    result   = (op_q == OP_MUL) ? acc_step : quot;

    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    dest_d    = dest_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d   = op_in;
          dest_d = bus.dest;
          cnt_d  = '0;
          acc_d  = '0;
          neg_d  = (op_in == OP_SDIV) && (bus.opA[XLEN-1] ^ bus.opB[XLEN-1]);
          a_d    = (op_in == OP_SDIV) ? abs_a : bus.opA;
          b_d    = (op_in == OP_SDIV) ? abs_b : bus.opB;
          // A zero divisor needs no iterations: the result is defined as 0.
          if (div_zero) begin
            state_d   = ST_DONE;
            wb_data_d = '0;
            wb_addr_d = bus.dest;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_step;
          a_d   = a_step;
          b_d   = b_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d   = ST_DONE;
            wb_data_d = result;
            wb_addr_d = dest_q;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      dest_q    <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.wb_en   = (state_q == ST_DONE) && !bus.flush;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops checked
// against an arithmetic reference model, with flush, reset and back-to-back scenarios.
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  muldiv_if #(.XLEN(32)) bus();

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference result straight from the arithmetic definition of each op.
  function automatic logic [31:0] ref_calc(input logic [1:0] op_v, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb;
    case (op_v)
      2'b01: return (b == 32'd0) ? 32'd0 : a / b;
      2'b10: begin
        if (b == 32'd0) return 32'd0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 32'(sa / sb);
      end
      default: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op_v, input logic [31:0] b);
    return ((op_v == 2'b01 || op_v == 2'b10) && b == 32'd0) ? 1 : 33;
  endfunction

  // Issues one op from a negedge with the unit idle and watches 40 cycles after acceptance.
  task automatic do_op(input logic [1:0] op_v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] d,
                       output int wb_cyc, output int wb_cnt, output int busy_cnt,
                       output logic [31:0] data, output logic [3:0] addr);
    bus.start = 1'b1;
    bus.op    = op_v;
    bus.opA   = a;
    bus.opB   = b;
    bus.dest  = d;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.opA   = $urandom;
    bus.opB   = $urandom;
    bus.dest  = 4'($urandom);
    wb_cyc = -1; wb_cnt = 0; busy_cnt = 0; data = '0; addr = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.wb_en) begin
        wb_cnt++;
        if (wb_cyc < 0) begin
          wb_cyc = i;
          data   = bus.wb_data;
          addr   = bus.wb_addr;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.wb_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wb_en got=%b exp=0", bus.wb_en); end
    total++; if (bus.wb_addr !== 4'd0) begin bad++; $display("[TB] FAIL reset_wb_addr got=%h exp=0", bus.wb_addr); end
    total++; if (bus.wb_data !== 32'd0) begin bad++; $display("[TB] FAIL reset_wb_data got=%h exp=0", bus.wb_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [1:0]  ops [6]  = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [31:0] as  [6]  = '{32'd7, 32'hFFFF_FFFF, 32'd100, 32'hFFFF_FF9C, 32'h8000_0000, 32'd9};
    logic [31:0] bs  [6]  = '{32'd6, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'hFFFF_FFFF, 32'd11};
    logic [31:0] exp [6]  = '{32'd42, 32'd1, 32'd14, 32'hFFFF_FFF2, 32'h8000_0000, 32'd99};
    int wc, wn, bc;
    logic [31:0] data;
    logic [3:0]  addr;
    for (int k = 0; k < 6; k++) begin
      do_op(ops[k], as[k], bs[k], 4'(k + 3), wc, wn, bc, data, addr);
      total++; if (wc != 33) begin bad++; $display("[TB] FAIL dir%0d_latency got=%0d exp=33", k, wc); end
      total++; if (wn != 1) begin bad++; $display("[TB] FAIL dir%0d_wb_count got=%0d exp=1", k, wn); end
      total++; if (bc != 33) begin bad++; $display("[TB] FAIL dir%0d_busy_cycles got=%0d exp=33", k, bc); end
      total++; if (data !== exp[k]) begin bad++; $display("[TB] FAIL dir%0d_data got=%h exp=%h", k, data, exp[k]); end
      total++; if (addr !== 4'(k + 3)) begin bad++; $display("[TB] FAIL dir%0d_addr got=%h exp=%h", k, addr, 4'(k + 3)); end
    end
  endtask

  task automatic test_div_zero();
    int wc, wn, bc;
    logic [31:0] data;
    logic [3:0]  addr;
    do_op(2'b01, 32'd5, 32'd0, 4'd9, wc, wn, bc, data, addr);
    total++; if (wc != 1) begin bad++; $display("[TB] FAIL udiv0_latency got=%0d exp=1", wc); end
    total++; if (bc != 1) begin bad++; $display("[TB] FAIL udiv0_busy_cycles got=%0d exp=1", bc); end
    total++; if (data !== 32'd0) begin bad++; $display("[TB] FAIL udiv0_data got=%h exp=0", data); end
    total++; if (addr !== 4'd9) begin bad++; $display("[TB] FAIL udiv0_addr got=%h exp=9", addr); end
    do_op(2'b10, 32'hFFFF_FF00, 32'd0, 4'd2, wc, wn, bc, data, addr);
    total++; if (wc != 1 || wn != 1) begin bad++; $display("[TB] FAIL sdiv0_latency got=%0d/%0d exp=1/1", wc, wn); end
    total++; if (data !== 32'd0) begin bad++; $display("[TB] FAIL sdiv0_data got=%h exp=0", data); end
  endtask

  task automatic test_random();
    int wc, wn, bc;
    logic [31:0] data, a, b;
    logic [3:0]  addr, d;
    logic [1:0]  op_v;
    for (int k = 0; k < 24; k++) begin
      op_v = 2'($urandom);
      a    = $urandom;
      b    = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (op_v == 2'b10 && $urandom_range(0, 1) == 1) b = -b;
      d    = 4'($urandom);
      do_op(op_v, a, b, d, wc, wn, bc, data, addr);
      total++; if (data !== ref_calc(op_v, a, b)) begin bad++; $display("[TB] FAIL rnd%0d_data op=%b a=%h b=%h got=%h exp=%h", k, op_v, a, b, data, ref_calc(op_v, a, b)); end
      total++; if (wc != ref_latency(op_v, b) || wn != 1) begin bad++; $display("[TB] FAIL rnd%0d_timing got=%0d/%0d exp=%0d/1", k, wc, wn, ref_latency(op_v, b)); end
      total++; if (addr !== d) begin bad++; $display("[TB] FAIL rnd%0d_addr got=%h exp=%h", k, addr, d); end
    end
  endtask

  task automatic test_flush();
    int wn, bn, wc, bc;
    logic [31:0] data;
    logic [3:0]  addr;
    bus.start = 1'b1; bus.op = 2'b00; bus.opA = 32'd123; bus.opB = 32'd456; bus.dest = 4'd4;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    total++; if (bus.wb_en !== 1'b0) begin bad++; $display("[TB] FAIL flush_run_wb_en got=%b exp=0", bus.wb_en); end
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_busy got=%b exp=0", bus.busy); end
    wn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.wb_en) wn++;
    end
    total++; if (wn != 0) begin bad++; $display("[TB] FAIL flush_no_wb got=%0d exp=0", wn); end
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.opA = 32'd50; bus.opB = 32'd0; bus.dest = 4'd8;
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
    wn = 0; bn = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.wb_en) wn++;
      if (bus.busy) bn++;
    end
    total++; if (wn != 0 || bn != 0) begin bad++; $display("[TB] FAIL flush_start_idle got=wb%0d/busy%0d exp=0/0", wn, bn); end
    do_op(2'b00, 32'd1000, 32'd1000, 4'd12, wc, wn, bc, data, addr);
    total++; if (data !== 32'd1000000 || wc != 33) begin bad++; $display("[TB] FAIL flush_next_op got=%h@%0d exp=%h@33", data, wc, 32'd1000000); end
  endtask

  task automatic test_busy_start();
    logic [31:0] a = $urandom, b = 32'($urandom_range(1, 5000));
    int wn = 0, wc = -1, bc;
    logic [31:0] data = '0;
    logic [3:0]  addr = '0;
    bus.start = 1'b1; bus.op = 2'b10; bus.opA = a; bus.opB = b; bus.dest = 4'd10;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.wb_en) begin
        wn++;
        if (wc < 0) begin wc = i; data = bus.wb_data; addr = bus.wb_addr; end
      end
      if (i == 5) begin bus.start = 1'b1; bus.op = 2'b00; bus.opA = 32'd3; bus.opB = 32'd3; bus.dest = 4'hE; end
      if (i == 8) bus.start = 1'b0;
    end
    total++; if (wn != 1 || wc != 33) begin bad++; $display("[TB] FAIL busy_start_wb got=%0d@%0d exp=1@33", wn, wc); end
    total++; if (data !== ref_calc(2'b10, a, b)) begin bad++; $display("[TB] FAIL busy_start_data got=%h exp=%h", data, ref_calc(2'b10, a, b)); end
    total++; if (addr !== 4'd10) begin bad++; $display("[TB] FAIL busy_start_addr got=%h exp=a", addr); end
    do_op(2'b01, 32'd77, 32'd5, 4'd1, wc, wn, bc, data, addr);
    total++; if (data !== 32'd15 || addr !== 4'd1) begin bad++; $display("[TB] FAIL busy_start_next got=%h/%h exp=f/1", data, addr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1 = $urandom, b1 = $urandom, a2 = $urandom, b2 = 32'($urandom_range(1, 1000));
    int n = 0, c1 = -1, c2 = -1;
    logic [31:0] d1 = '0, d2 = '0;
    logic [3:0]  ad2 = '0;
    logic        idle_seen = 1'b0;
    bus.start = 1'b1; bus.op = 2'b00; bus.opA = a1; bus.opB = b1; bus.dest = 4'd5;
    @(posedge clk);
    #1;
    bus.op = 2'b01; bus.opA = a2; bus.opB = b2; bus.dest = 4'd6;
    for (int i = 1; i <= 75; i++) begin
      @(negedge clk);
      if (i == 34) idle_seen = !bus.busy;
      if (bus.wb_en) begin
        if (n == 0) begin c1 = i; d1 = bus.wb_data; end
        else if (n == 1) begin c2 = i; d2 = bus.wb_data; ad2 = bus.wb_addr; end
        n++;
      end
      if (i == 40) bus.start = 1'b0;
    end
    total++; if (n != 2) begin bad++; $display("[TB] FAIL b2b_wb_count got=%0d exp=2", n); end
    total++; if (c1 != 33 || c2 != 67) begin bad++; $display("[TB] FAIL b2b_timing got=%0d,%0d exp=33,67", c1, c2); end
    total++; if (idle_seen !== 1'b1) begin bad++; $display("[TB] FAIL b2b_idle_gap got=%b exp=1", idle_seen); end
    total++; if (d1 !== ref_calc(2'b00, a1, b1)) begin bad++; $display("[TB] FAIL b2b_data1 got=%h exp=%h", d1, ref_calc(2'b00, a1, b1)); end
    total++; if (d2 !== ref_calc(2'b01, a2, b2) || ad2 !== 4'd6) begin bad++; $display("[TB] FAIL b2b_data2 got=%h/%h exp=%h/6", d2, ad2, ref_calc(2'b01, a2, b2)); end
  endtask

  task automatic test_reset_mid();
    int wn, bn, wc, bc;
    logic [31:0] data, a, b;
    logic [3:0]  addr;
    bus.start = 1'b1; bus.op = 2'b00; bus.opA = 32'hDEAD_BEEF; bus.opB = 32'h1234_5677; bus.dest = 4'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0 || bus.wb_en !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_ctrl got=busy%b/wb%b exp=0/0", bus.busy, bus.wb_en); end
    total++; if (bus.wb_addr !== 4'd0 || bus.wb_data !== 32'd0) begin bad++; $display("[TB] FAIL rstmid_outputs got=%h/%h exp=0/0", bus.wb_addr, bus.wb_data); end
    wn = 0; bn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.wb_en) wn++;
      if (bus.busy) bn++;
    end
    total++; if (wn != 0 || bn != 0) begin bad++; $display("[TB] FAIL rstmid_quiet got=wb%0d/busy%0d exp=0/0", wn, bn); end
    a = $urandom; b = 32'($urandom_range(1, 300));
    do_op(2'b01, a, b, 4'd13, wc, wn, bc, data, addr);
    total++; if (data !== ref_calc(2'b01, a, b) || addr !== 4'd13 || wc != 33) begin bad++; $display("[TB] FAIL rstmid_next got=%h/%h@%0d exp=%h/d@33", data, addr, wc, ref_calc(2'b01, a, b)); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00;
    bus.opA = '0; bus.opB = '0; bus.dest = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_div_zero();
    test_random();
    test_flush();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
